// File: rtl/gpio_pulse_seq_if.sv
// rtl/gpio_pulse_seq_if.sv - iomem bus bundle between the pulse sequencer and the GPIO slave
interface gpio_pulse_seq_if;
  logic [31:0] iomem_addr;
  logic        iomem_valid;
  logic        iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;

  modport master (
    output iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
    input  iomem_rdata, iomem_ready
  );

  modport slave (
    input  iomem_addr, iomem_valid, iomem_wstrb, iomem_wdata,
    output iomem_rdata, iomem_ready
  );
endinterface

// File: rtl/gpio_pulse_seq.sv
// rtl/gpio_pulse_seq.sv - serialises a bit pattern onto a GPIO pad over iomem and samples it back
module gpio_pulse_seq #(
  parameter logic [31:0] BASE_ADR  = 32'h2100_0000,
  parameter logic [7:0]  GPIO_DATA = 8'h00,
  parameter logic [7:0]  GPIO_ENA  = 8'h04,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [15:0]      pattern,
  input  logic [4:0]       nbits,
  input  logic [15:0]      half_period,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      rx_data,
  gpio_pulse_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, OE_ON, WR_BIT, WAIT1, RD_BIT, WAIT2, OE_OFF, FIN
  } state_e;

  state_e      state_q;
  logic        busy_q, done_q, error_q;
  logic [15:0] rx_q, pat_q, hp_q, wcnt_q;
  logic [4:0]  rem_q;
  logic [7:0]  tcnt_q;
  logic        valid_q, wstrb_q;
  logic [31:0] addr_q, wdata_q;

  logic [4:0]  nbits_eff;
  logic [3:0]  bit_idx;
  logic [7:0]  acc_off;
  logic        acc_bit, tmo_hit, wait_over;
  logic        unused_rdata;

  always_comb begin
    nbits_eff = (nbits > 5'd16) ? 5'd16 : nbits;
    bit_idx   = 4'(rem_q - 5'd1);
    acc_off   = (state_q == WR_BIT || state_q == RD_BIT) ? GPIO_DATA : GPIO_ENA;
    acc_bit   = 1'b0;
    if (state_q == WR_BIT) acc_bit = pat_q[bit_idx];
    else if (state_q == OE_OFF) acc_bit = 1'b1;
    tmo_hit   = ({1'b0, tcnt_q} + 9'd1) >= {1'b0, TIMEOUT};
    wait_over = wcnt_q >= hp_q;
  end

  // Each access starts with valid low for one cycle, which keeps a gap after every ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rx_q    <= 16'd0;
      pat_q   <= 16'd0;
      hp_q    <= 16'd0;
      wcnt_q  <= 16'd0;
      rem_q   <= 5'd0;
      tcnt_q  <= 8'd0;
      valid_q <= 1'b0;
      wstrb_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q   <= pattern;
            rem_q   <= nbits_eff;
            hp_q    <= half_period;
            rx_q    <= 16'd0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (nbits_eff == 5'd0) ? FIN : OE_ON;
          end
        end
        OE_ON, WR_BIT, RD_BIT, OE_OFF: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            tcnt_q  <= 8'd0;
            addr_q  <= {BASE_ADR[31:8], acc_off};
            wstrb_q <= (state_q != RD_BIT);
            wdata_q <= {31'd0, acc_bit};
          end else if (bus.iomem_ready) begin
            valid_q <= 1'b0;
            wcnt_q  <= 16'd1;
            if (state_q == OE_ON) state_q <= WR_BIT;
            else if (state_q == WR_BIT) state_q <= WAIT1;
            else if (state_q == RD_BIT) begin
              rx_q    <= {rx_q[14:0], bus.iomem_rdata[0]};
              state_q <= WAIT2;
            end else state_q <= FIN;
          end else if (tmo_hit) begin
            valid_q <= 1'b0;
            error_q <= 1'b1;
            state_q <= (state_q == OE_OFF) ? FIN : OE_OFF;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        WAIT1: begin
          if (wait_over) state_q <= RD_BIT;
          else wcnt_q <= wcnt_q + 16'd1;
        end
        WAIT2: begin
          if (wait_over) begin
            rem_q   <= rem_q - 5'd1;
            state_q <= (rem_q == 5'd1) ? OE_OFF : WR_BIT;
          end else begin
            wcnt_q <= wcnt_q + 16'd1;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign rx_data = rx_q;

  assign bus.iomem_valid = valid_q;
  assign bus.iomem_wstrb = wstrb_q;
  assign bus.iomem_addr  = addr_q;
  assign bus.iomem_wdata = wdata_q;

  assign unused_rdata = ^bus.iomem_rdata[31:1];

endmodule

// File: tb/tb_gpio_pulse_seq.sv
// tb/tb_gpio_pulse_seq.sv - directed self-checking bench for gpio_pulse_seq with a looped-back GPIO slave
module tb_gpio_pulse_seq;
  localparam logic [31:0] ADR_DATA = 32'h2100_0000;
  localparam logic [31:0] ADR_ENA  = 32'h2100_0004;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [15:0] pattern, half_period;
  logic [4:0]  nbits;
  logic        busy, done, error;
  logic [15:0] rx_data;

  always #5 clk = ~clk;

  gpio_pulse_seq_if bus ();

  gpio_pulse_seq dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .pattern     (pattern),
    .nbits       (nbits),
    .half_period (half_period),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rx_data     (rx_data),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int   lat = 1;
  bit   never_ready = 0;
  logic pad = 1'b0;
  int   rcnt = 0, run_len = 0;
  bit   prev_ack = 0, prev_valid = 0;
  int   valid_cycles = 0, done_pulses = 0, proto_err = 0, data_wr = 0;
  logic [31:0] acc_addr[$], acc_wdata[$], att_addr[$], att_wdata[$];
  logic        acc_we[$];
  int          runs[$];
  logic [31:0] exp_addr[$], exp_wdata[$];
  logic        exp_we[$];

  // Slave with one wait cycle; the pad follows the last DATA write and reads back on rdata[0].
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (bus.iomem_valid) begin
      valid_cycles++;
      run_len++;
      if (prev_ack) proto_err++;
      if (!prev_valid) begin
        att_addr.push_back(bus.iomem_addr);
        att_wdata.push_back(bus.iomem_wdata);
      end
    end else if (prev_valid) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    prev_valid = bus.iomem_valid;
    if (bus.iomem_valid && !never_ready) begin
      bus.iomem_ready = (rcnt >= lat);
      rcnt++;
    end else begin
      bus.iomem_ready = 1'b0;
      rcnt = 0;
    end
    prev_ack = bus.iomem_valid && bus.iomem_ready;
    if (prev_ack) begin
      acc_addr.push_back(bus.iomem_addr);
      acc_we.push_back(bus.iomem_wstrb);
      acc_wdata.push_back(bus.iomem_wdata);
      if (bus.iomem_wstrb) begin
        if (bus.iomem_wdata[31:1] != 31'd0) proto_err++;
        if (bus.iomem_addr == ADR_DATA) begin
          pad = bus.iomem_wdata[0];
          data_wr++;
        end
      end else if (bus.iomem_wdata != 32'd0) begin
        proto_err++;
      end
    end
    bus.iomem_rdata = {31'd0, pad};
  end

  function automatic void build_exp(input logic [15:0] p, input int n);
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete();
    exp_addr.push_back(ADR_ENA); exp_we.push_back(1'b1); exp_wdata.push_back(32'd0);
    for (int i = n - 1; i >= 0; i--) begin
      exp_addr.push_back(ADR_DATA); exp_we.push_back(1'b1); exp_wdata.push_back({31'd0, p[i]});
      exp_addr.push_back(ADR_DATA); exp_we.push_back(1'b0); exp_wdata.push_back(32'd0);
    end
    exp_addr.push_back(ADR_ENA); exp_we.push_back(1'b1); exp_wdata.push_back(32'd1);
  endfunction

  task automatic clear_mon();
    acc_addr.delete(); acc_we.delete(); acc_wdata.delete();
    att_addr.delete(); att_wdata.delete(); runs.delete();
    valid_cycles = 0; done_pulses = 0; proto_err = 0; data_wr = 0;
  endtask

  task automatic do_start(input logic [15:0] p, input logic [4:0] n, input logic [15:0] hp);
    @(negedge clk);
    pattern = p; nbits = n; half_period = hp; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles = clock edges after the launch edge before done is visible
  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 0; cycles = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      cycles++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; pattern = 16'd0; nbits = 5'd0; half_period = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error});
    end
    n_checks++;
    if (rx_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_rx: got %h expected 0000", rx_data);
    end
    n_checks++;
    if ({bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata} !== 66'd0) begin
      n_fail++; $display("FAIL reset_bus: got valid=%b wstrb=%b addr=%h wdata=%h expected all 0",
                         bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit ok;
    clear_mon();
    build_exp(16'hA5A5, 8);
    do_start(16'hA5A5, 5'd8, 16'd2);
    wait_done(500, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no done expected done within 500 cycles"); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_addr.size() != 18) begin
      n_fail++; $display("FAIL basic_count: got %0d accesses expected 18", acc_addr.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        n_checks++;
        if (acc_addr[i] !== exp_addr[i] || acc_we[i] !== exp_we[i] || acc_wdata[i] !== exp_wdata[i]) begin
          n_fail++;
          $display("FAIL basic_access[%0d]: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   i, acc_addr[i], acc_we[i], acc_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
        end
      end
    end
    n_checks++;
    if (rx_data !== 16'h00A5) begin n_fail++; $display("FAIL basic_rx: got %h expected 00a5", rx_data); end
    n_checks++;
    if (done_pulses != 1 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: got done_pulses=%0d error=%b busy=%b expected 1 0 0",
                         done_pulses, error, busy);
    end
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_zero_bits();
    clear_mon();
    do_start(16'hFFFF, 5'd0, 16'd3);
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL zero_cycle1: got busy,done=%b expected 10", {busy, done}); end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL zero_cycle2: got busy,done=%b expected 01", {busy, done}); end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL zero_cycle3: got busy,done=%b expected 00", {busy, done}); end
    n_checks++;
    if (valid_cycles != 0) begin n_fail++; $display("FAIL zero_novalid: got %0d valid cycles expected 0", valid_cycles); end
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    clear_mon();
    never_ready = 1;
    do_start(16'h0001, 5'd4, 16'd1);
    wait_done(800, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_done: got no done expected done within 800 cycles"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (runs.size() < 1 || runs[0] != 255) begin
      n_fail++; $display("FAIL timeout_len: got %0d runs first=%0d expected first run 255",
                         runs.size(), (runs.size() > 0) ? runs[0] : -1);
    end
    n_checks++;
    if (att_addr.size() != 2 || att_addr[1] !== ADR_ENA || att_wdata[1] !== 32'd1) begin
      n_fail++; $display("FAIL timeout_oe_off: got %0d attempts expected 2 with second ENA<=1", att_addr.size());
    end
    n_checks++;
    if (error !== 1'b1 || done_pulses != 1 || acc_addr.size() != 0) begin
      n_fail++; $display("FAIL timeout_status: got error=%b done_pulses=%0d accesses=%0d expected 1 1 0",
                         error, done_pulses, acc_addr.size());
    end
    never_ready = 0;
  endtask

  task automatic test_busy_ignore();
    bit ok;
    clear_mon();
    build_exp(16'hA5A5, 8);
    do_start(16'hA5A5, 5'd8, 16'd2);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      if (c % 7 == 3) begin start = 1'b1; pattern = 16'h5A5A; nbits = 5'd3; half_period = 16'd0; end
      @(posedge clk);
      #1 start = 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL busy_done: got no done expected done within 500 cycles"); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (acc_addr.size() != 18) begin
      n_fail++; $display("FAIL busy_count: got %0d accesses expected 18", acc_addr.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        n_checks++;
        if (acc_addr[i] !== exp_addr[i] || acc_we[i] !== exp_we[i] || acc_wdata[i] !== exp_wdata[i]) begin
          n_fail++;
          $display("FAIL busy_access[%0d]: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   i, acc_addr[i], acc_we[i], acc_wdata[i], exp_addr[i], exp_we[i], exp_wdata[i]);
        end
      end
    end
    n_checks++;
    if (rx_data !== 16'h00A5 || error !== 1'b0 || done_pulses != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_status: got rx=%h error=%b done_pulses=%0d busy=%b expected 00a5 0 1 0",
                         rx_data, error, done_pulses, busy);
    end
  endtask

  task automatic test_half_period();
    int cyc; bit ok;
    int exp_cyc[3] = '{15, 15, 17};
    for (int hp = 0; hp < 3; hp++) begin
      clear_mon();
      do_start(16'h0001, 5'd1, hp[15:0]);
      wait_done(200, cyc, ok);
      n_checks++;
      if (!ok || cyc != exp_cyc[hp]) begin
        n_fail++; $display("FAIL half_period_%0d: got %0d cycles (done=%b) expected %0d", hp, cyc, ok, exp_cyc[hp]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_max_bits();
    int cyc; bit ok;
    clear_mon();
    do_start(16'hBEEF, 5'd20, 16'd0);
    wait_done(500, cyc, ok);
    n_checks++;
    if (!ok || rx_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL max_bits_rx: got rx=%h done=%b expected beef 1", rx_data, ok);
    end
    n_checks++;
    if (data_wr != 16 || acc_addr.size() != 34) begin
      n_fail++; $display("FAIL max_bits_count: got %0d data writes %0d accesses expected 16 34", data_wr, acc_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, vc; bit ok;
    clear_mon();
    do_start(16'h00FF, 5'd8, 16'd4);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (data_wr == 3) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_reach: got %0d data writes expected 3", data_wr); end
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, error} !== 3'b000 || rx_data !== 16'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got busy,done,error=%b rx=%h expected 000 0000", {busy, done, error}, rx_data);
    end
    n_checks++;
    if ({bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata} !== 66'd0) begin
      n_fail++; $display("FAIL midreset_bus: got valid=%b wstrb=%b addr=%h wdata=%h expected all 0",
                         bus.iomem_valid, bus.iomem_wstrb, bus.iomem_addr, bus.iomem_wdata);
    end
    resetn = 1'b1;
    vc = valid_cycles;
    repeat (10) @(negedge clk);
    n_checks++;
    if (valid_cycles != vc || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d extra valid cycles busy=%b expected 0 0", valid_cycles - vc, busy);
    end
    clear_mon();
    do_start(16'h00C3, 5'd8, 16'd1);
    wait_done(500, cyc, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok || rx_data !== 16'h00C3 || error !== 1'b0 || acc_addr.size() != 18 || proto_err != 0) begin
      n_fail++; $display("FAIL midreset_rerun: got done=%b rx=%h error=%b accesses=%0d violations=%0d expected 1 00c3 0 18 0",
                         ok, rx_data, error, acc_addr.size(), proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_bits();
    test_timeout();
    test_busy_ignore();
    test_half_period();
    test_max_bits();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
